// File: rtl/count_run_arbiter_pkg.sv
// Shared types for the count-run arbiter: FSM state encoding, requester count
// and the round-robin winner selection.
package count_run_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // On a tie the requester not granted last wins; a lone request wins outright.
    function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req_v,
                                        input req_id_t            last_v);
        if (&req_v) begin
            return ~last_v;
        end
        if (req_v[1]) begin
            return req_id_t'(1);
        end
        return req_id_t'(0);
    endfunction

endpackage

// File: rtl/count_run_arbiter_counter_unit.sv
// Shared run counter: synchronous clear has priority over increment, and the
// value saturates at all-ones instead of wrapping.
module counter_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_run_arbiter.sv
// Two-requester round-robin arbiter that lends a shared counter for a run of
// len ticks, then pulses done with the owner's id.
module count_run_arbiter
    import count_run_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   len0,
    input  logic [WIDTH-1:0]   len1,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [WIDTH-1:0]   count
);

    state_e           state_q, state_d;
    req_id_t          id_q, id_d;
    req_id_t          last_q, last_d;
    logic [WIDTH-1:0] len_q, len_d;

    req_id_t          winner;
    logic             owner_req;
    logic             run_last;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH:0]   count_inc;

    counter_unit #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    // Compared one bit wider so a full-scale run length cannot alias to zero.
    assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign run_last  = (count_inc == {1'b0, len_q});
    assign owner_req = req[id_q];
    assign winner    = rr_pick(req, last_q);

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    id_d    = winner;
                    last_d  = winner;
                    len_d   = winner ? len1 : len0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_clr = 1'b1;
                    state_d = (len_q != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // A withdrawn owner freezes the counter where it stands.
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (run_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_q resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            id_q    <= req_id_t'(0);
            last_q  <= req_id_t'(1);
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        busy     = (state_q == ST_GRANT) || (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        done_id  = id_q;
        gnt      = '0;
        if (busy) begin
            gnt[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_count_run_arbiter.sv
// Self-checking bench for count_run_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_count_run_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] len0 = '0;
    logic [WIDTH-1:0] len1 = '0;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model: a run is described by its owner, its latched length and
    // the number of cycles elapsed since the grant cycle (0 = grant cycle,
    // 1..len = run cycles, len+1 = done cycle).
    bit m_active;
    int m_owner;
    int m_last;
    int m_len;
    int m_elapsed;
    int m_count;

    count_run_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .count   (count)
    );

    always #5 clk = ~clk;

    function void model_reset();
        m_active  = 1'b0;
        m_owner   = 0;
        m_last    = 1;
        m_len     = 0;
        m_elapsed = 0;
        m_count   = 0;
    endfunction

    function void model_edge(input logic [1:0] r, input int l0, input int l1);
        if (!m_active) begin
            if (r != 2'b00) begin
                if (r == 2'b11) m_owner = 1 - m_last;
                else            m_owner = r[1] ? 1 : 0;
                m_last    = m_owner;
                m_len     = (m_owner == 1) ? l1 : l0;
                m_elapsed = 0;
                m_active  = 1'b1;
            end
        end else if (m_elapsed <= m_len) begin
            if (!r[m_owner]) begin
                m_active = 1'b0;
            end else begin
                m_count   = (m_elapsed == 0) ? 0 : m_count + 1;
                m_elapsed = m_elapsed + 1;
            end
        end else begin
            m_active = 1'b0;
        end
    endfunction

    // Expected {gnt, busy, done, count} for the current model position.
    function automatic logic [WIDTH+3:0] exp_vec();
        logic [1:0] g;
        logic       b;
        logic       d;
        g = 2'b00;
        b = 1'b0;
        d = 1'b0;
        if (m_active && (m_elapsed <= m_len)) begin
            g[m_owner] = 1'b1;
            b = 1'b1;
        end else if (m_active) begin
            d = 1'b1;
        end
        return {g, b, d, m_count[WIDTH-1:0]};
    endfunction

    // One clock: the model consumes the pre-edge inputs, outputs are then
    // allowed to settle before anyone looks at them.
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge(req, int'(len0), int'(len1));
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00;
        #2 reset = 1'b0;
        model_reset();
        step();
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({gnt, busy, done, done_id, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {gnt, busy, done, done_id, count});
        end
        model_reset();
        step();
        #3 reset = 1'b1;
        step();
        checks++;
        if ({gnt, busy, done, count} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", {gnt, busy, done, count}, exp_vec());
        end
    endtask

    task automatic test_single();
        int runs = 0;
        do_reset();
        req  = 2'b01;
        len0 = 4'd3;
        step();
        checks++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b busy=%b expected gnt=01 busy=1", gnt, busy);
        end
        len0 = 4'd9;  // must not affect the run already granted
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL single_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (gnt == 2'b01) runs++;
            if (done) break;
        end
        checks++;
        if (runs != 3 || done !== 1'b1 || done_id !== 1'b0 || count !== 4'd3 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL single_done: got runs=%0d done=%b id=%b count=%0d gnt=%b expected 3 1 0 3 00",
                     runs, done, done_id, count, gnt);
        end
        req = 2'b00;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] grants[3];
        int         gcyc[3];
        int         dcyc[3];
        int         ng = 0;
        int         nd = 0;
        logic [1:0] prev_gnt = 2'b00;
        do_reset();
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd1;
        for (int i = 0; i < 40 && ng < 3; i++) begin
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL contention_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (done && nd < 3) begin
                dcyc[nd] = i;
                nd++;
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                grants[ng] = gnt;
                gcyc[ng]   = i;
                ng++;
            end
            prev_gnt = gnt;
        end
        checks++;
        if (ng != 3) begin
            failures++;
            $display("FAIL contention_timeout: got %0d grants expected 3", ng);
        end else if (grants[0] !== 2'b01 || grants[1] !== 2'b10 || grants[2] !== 2'b01) begin
            failures++;
            $display("FAIL contention_order: got %b %b %b expected 01 10 01", grants[0], grants[1], grants[2]);
        end else if (gcyc[1] - dcyc[0] != 2 || gcyc[2] - dcyc[1] != 2) begin
            failures++;
            $display("FAIL contention_gap: got %0d %0d expected 2 2", gcyc[1] - dcyc[0], gcyc[2] - dcyc[1]);
        end
        req = 2'b00;
        step();
        step();
    endtask

    task automatic test_zero_len();
        do_reset();
        req  = 2'b01;
        len0 = 4'd2;
        for (int i = 0; i < 6; i++) step();  // leave a nonzero count behind
        req  = 2'b10;
        len1 = 4'd0;
        step();
        step();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL zero_grant: got gnt=%b expected 10", gnt);
        end
        step();
        checks++;
        if (done !== 1'b1 || done_id !== 1'b1 || count !== 4'd0 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL zero_done: got done=%b id=%b count=%0d gnt=%b expected 1 1 0 00",
                     done, done_id, count, gnt);
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_max_len();
        int runs = 0;
        do_reset();
        req  = 2'b01;
        len0 = 4'd15;
        step();
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL max_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (gnt == 2'b01) runs++;
            if (done) break;
        end
        checks++;
        if (runs != 15 || done !== 1'b1 || count !== 4'd15) begin
            failures++;
            $display("FAIL max_done: got runs=%0d done=%b count=%0d expected 15 1 15", runs, done, count);
        end
        req = 2'b00;
        step();
        checks++;
        if (count !== 4'd15 || busy !== 1'b0) begin
            failures++;
            $display("FAIL max_nowrap: got count=%0d busy=%b expected 15 0", count, busy);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req  = 2'b11;
        len0 = 4'd8;
        len1 = 4'd2;
        step();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL withdraw_grant: got gnt=%b expected 01", gnt);
        end
        step();
        step();
        req = 2'b10;  // requester 0 drops during its second run cycle
        step();
        checks++;
        if ({gnt, busy, done, count} !== {2'b00, 1'b0, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL withdraw_idle: got %h expected %h", {gnt, busy, done, count}, {2'b00, 1'b0, 1'b0, 4'd1});
        end
        step();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("FAIL withdraw_next: got gnt=%b expected 10", gnt);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL withdraw_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (done) break;
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req  = 2'b01;
        len0 = 4'd10;
        for (int i = 0; i < 4; i++) step();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, done, done_id, count} !== '0) begin
            failures++;
            $display("FAIL async_abort: got %h expected 0", {gnt, busy, done, done_id, count});
        end
        model_reset();
        step();
        checks++;
        if ({gnt, busy, done, count} !== '0) begin
            failures++;
            $display("FAIL async_hold: got %h expected 0", {gnt, busy, done, count});
        end
        len0 = 4'd2;
        #2 reset = 1'b1;
        step();
        checks++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_resume: got gnt=%b busy=%b expected 01 1", gnt, busy);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL async_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (done) break;
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(3) == 0)
                len0 = ($urandom_range(4) == 0) ? 4'd15 : WIDTH'($urandom_range(5));
            if ($urandom_range(3) == 0)
                len1 = ($urandom_range(4) == 0) ? 4'd15 : WIDTH'($urandom_range(5));
            step();
            checks++;
            if ({gnt, busy, done, count} !== exp_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d: got %h expected %h", i, {gnt, busy, done, count}, exp_vec());
            end
            if (done) begin
                checks++;
                if (done_id !== m_owner[0]) begin
                    failures++;
                    $display("FAIL random_id%0d: got %b expected %0d", i, done_id, m_owner);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_zero_len();
        test_max_len();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
